// File: rtl/dff_chk_pkg.sv
// Shared types and helpers for the D flip-flop response checker.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } chk_state_t;

    localparam int LAT_MAX = 4;

    // Increment that sticks at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        return (v >= max) ? max : v + 32'd1;
    endfunction

endpackage

// File: rtl/dff_model_pipe.sv
// Golden model: LAT-deep chain of D flops cleared whenever the DUT reset is high.
module dff_model_pipe #(
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           dut_d,
    input  logic           dut_rst,
    output logic [LAT-1:0] exp_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= '0;
        end else if (dut_rst) begin
            exp_q <= '0;
        end else begin
            exp_q[0] <= dut_d;
            for (int i = 1; i < LAT; i++) begin
                exp_q[i] <= exp_q[i-1];
            end
        end
    end

endmodule

// File: rtl/dff_response_checker.sv
// Response monitor: compares dut_q against a golden flop chain each edge of a run
// and accumulates saturating cycle/error counts plus the first failing cycle.
module dff_response_checker #(
    parameter int LAT   = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dut_d,
    input  logic             dut_rst,
    input  logic             dut_q,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic             pass,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail_cyc
);
    import dff_chk_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               WARM_W  = $clog2(LAT_MAX);

    chk_state_t        state;
    logic [WARM_W-1:0] warm_cnt;
    logic [LAT-1:0]    exp_q;
    logic              exp_bit;
    logic              mismatch;

    dff_model_pipe #(.LAT(LAT)) u_model (
        .clk     (clk),
        .rst     (rst),
        .dut_d   (dut_d),
        .dut_rst (dut_rst),
        .exp_q   (exp_q)
    );

    // The DUT clears asynchronously, so its reset masks the expected value at once.
    assign exp_bit  = dut_rst ? 1'b0 : exp_q[LAT-1];
    assign mismatch = (dut_q !== exp_bit);

    assign busy = (state == WARM) || (state == RUN);
    assign done = (state == DONE);
    assign pass = done && !fail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            warm_cnt       <= '0;
            fail           <= 1'b0;
            cyc_cnt        <= '0;
            err_cnt        <= '0;
            first_fail_cyc <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= WARM;
                        warm_cnt       <= '0;
                        fail           <= 1'b0;
                        cyc_cnt        <= '0;
                        err_cnt        <= '0;
                        first_fail_cyc <= '0;
                    end
                end
                WARM: begin
                    if (stop) begin
                        state <= DONE;
                    end else if (warm_cnt == WARM_W'(LAT - 1)) begin
                        state <= RUN;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                RUN: begin
                    cyc_cnt <= CNT_W'(sat_inc(32'(cyc_cnt), 32'(CNT_MAX)));
                    if (mismatch) begin
                        err_cnt <= CNT_W'(sat_inc(32'(err_cnt), 32'(CNT_MAX)));
                        if (!fail) begin
                            first_fail_cyc <= cyc_cnt;
                            fail           <= 1'b1;
                        end
                    end
                    if (stop) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
